// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: W-bit ALU operation sequenced as NIBBLES passes through an
// external 4-bit ALU slice. Operands are latched on start. Each RUN cycle drives
// one nibble to the slice, writes back its data output and threads the carry or
// shift bit to the next pass.
module alu_nibble_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [2:0]           func,
  input  logic                 com,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic                 eq,
  output logic [3:0]           slice_a,
  output logic [3:0]           slice_b,
  output logic [2:0]           slice_f,
  output logic                 slice_com,
  output logic                 slice_ci_left,
  output logic                 slice_ci_right,
  input  logic [3:0]           slice_d,
  input  logic                 slice_co_left,
  input  logic                 slice_co_right,
  input  logic                 slice_equ
);

  localparam int W = 4 * NIBBLES;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SHL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_accept;
  logic           w_last;
  logic [1:0]     r_k;
  logic [1:0]     w_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2:0]     r_func;
  logic           r_com;
  logic           r_carry;
  logic           w_carry_nxt;
  logic           r_eq;
  logic [W-1:0]   r_result;

  assign w_last = (r_k == 2'(NIBBLES - 1));

  // SHR walks from the most significant nibble down; every other function
  // walks from the least significant nibble up.
  assign w_idx = (r_func == F_SHR) ? (2'(NIBBLES - 1) - r_k) : r_k;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus busy/done status and start acceptance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slice drive: active only in RUN, all zero otherwise.
  always_comb begin
    slice_a        = 4'h0;
    slice_b        = 4'h0;
    slice_f        = 3'd0;
    slice_com      = 1'b0;
    slice_ci_left  = 1'b0;
    slice_ci_right = 1'b0;
    if (r_state == S_RUN) begin
      slice_a   = r_a[w_idx*4 +: 4];
      slice_b   = r_b[w_idx*4 +: 4];
      slice_f   = r_func;
      slice_com = r_com;
      case (r_func)
        F_ADD, F_SHL: slice_ci_right = r_carry;
        F_SHR:        slice_ci_left  = r_carry;
        default:      ;
      endcase
    end
  end

  // Carry or shift bit handed from this pass to the next one.
  always_comb begin
    case (r_func)
      F_ADD, F_SHL: w_carry_nxt = slice_co_left;
      F_SHR:        w_carry_nxt = slice_co_right;
      default:      w_carry_nxt = 1'b0;
    endcase
  end

  // Operand and mode latches, loaded only when a start is accepted.
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. They are read only in RUN, which
    // can only be entered through a load, and the slice outputs are gated to
    // zero outside RUN.
    if (w_accept) begin
      r_a    <= op_a;
      r_b    <= op_b;
      r_func <= func;
      r_com  <= com;
    end
  end

  // Pass counter, result assembly, carry and equality accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= 2'd0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_eq     <= 1'b0;
    end else if (w_accept) begin
      r_k     <= 2'd0;
      r_carry <= cin;
      r_eq    <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_k                   <= r_k + 2'd1;
      r_result[w_idx*4 +: 4] <= slice_d;
      r_carry               <= w_carry_nxt;
      r_eq                  <= r_eq & slice_equ;
    end
  end

  assign result = r_result;
  assign cout   = r_carry;
  assign zero   = (r_result == '0);
  assign eq     = r_eq;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: drives directed and random operations into alu_nibble_seq.
// A behavioural 4-bit slice is attached to the slice port. Whole-word results
// come from an arithmetic reference model and are queued as the expected
// response. A monitor compares each done pulse against the queue.
module tb_alu_nibble_seq;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic [2:0]   func;
  logic         com, cin;
  logic         busy, done, cout, zero, eq;
  logic [W-1:0] result;
  logic [3:0]   slice_a, slice_b, slice_d;
  logic [2:0]   slice_f;
  logic         slice_com, slice_ci_left, slice_ci_right;
  logic         slice_co_left, slice_co_right, slice_equ;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         eq;
    int           done_cyc;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [W-1:0] last_res;
  logic [4:0]   s_sum;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .func(func), .com(com), .cin(cin), .busy(busy), .done(done),
    .result(result), .cout(cout), .zero(zero), .eq(eq),
    .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f),
    .slice_com(slice_com), .slice_ci_left(slice_ci_left),
    .slice_ci_right(slice_ci_right), .slice_d(slice_d),
    .slice_co_left(slice_co_left), .slice_co_right(slice_co_right),
    .slice_equ(slice_equ)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check done latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit ALU slice.
  always_comb begin
    s_sum          = 5'd0;
    slice_d        = 4'h0;
    slice_co_left  = 1'b0;
    slice_co_right = 1'b0;
    slice_equ      = (slice_a == slice_b);
    case (slice_f)
      3'd0: begin
        s_sum         = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_ci_right};
        slice_d       = s_sum[3:0];
        slice_co_left = s_sum[4];
      end
      3'd1: slice_d = slice_a & slice_b;
      3'd2: slice_d = slice_a | slice_b;
      3'd3: slice_d = slice_a ^ slice_b;
      3'd4: slice_d = slice_a;
      3'd5: slice_d = slice_b;
      3'd6: begin
        slice_d        = {slice_ci_left, slice_a[3:1]};
        slice_co_right = slice_a[0];
      end
      default: begin
        slice_d       = {slice_a[2:0], slice_ci_right};
        slice_co_left = slice_a[3];
      end
    endcase
    if (slice_com) slice_d = ~slice_d;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Whole-word reference: the operation the sequence of passes must add up to.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] f, input logic c, input logic ci);
    exp_t       e;
    logic [W:0] s;
    e.cout = 1'b0;
    case (f)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        e.res  = s[W-1:0];
        e.cout = s[W];
      end
      3'd1: e.res = a & b;
      3'd2: e.res = a | b;
      3'd3: e.res = a ^ b;
      3'd4: e.res = a;
      3'd5: e.res = b;
      3'd6: begin e.res = {ci, a[W-1:1]}; e.cout = a[0];   end
      default: begin e.res = {a[W-2:0], ci}; e.cout = a[W-1]; end
    endcase
    if (c) e.res = ~e.res;
    e.zero     = (e.res == '0);
    e.eq       = (a == b);
    e.done_cyc = 0;
    return e;
  endfunction

  // Issue one operation starting at a negedge. Returns at the negedge inside
  // its DONE cycle. With junk set, start is re-asserted with other operands
  // during every pass.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input logic c, input logic ci,
                        input bit junk);
    exp_t e;
    int   idx;
    e          = model(a, b, f, c, ci);
    e.done_cyc = cyc + 1 + N;
    q.push_back(e);
    last_res = e.res;
    op_a = a; op_b = b; func = f; com = c; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < N; p++) begin
      idx = (f == 3'd6) ? (N - 1 - p) : p;
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("slice_a", 32'(slice_a), 32'((a >> (4 * idx)) & 4'hF));
      check("slice_b", 32'(slice_b), 32'((b >> (4 * idx)) & 4'hF));
      check("slice_f", 32'(slice_f), 32'(f));
      if (junk) begin
        op_a = ~a; op_b = a ^ b; func = f + 3'd1; com = ~c; cin = ~ci;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // One cycle with no request, checking the idle outputs.
  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_slice", 32'({slice_a, slice_b, slice_f, slice_com,
                            slice_ci_left, slice_ci_right}), 32'd0);
    check("held_result", 32'(result), 32'(last_res));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
    check({tag, "_eq"}, 32'(eq), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd1);
    check({tag, "_slice"}, 32'({slice_a, slice_b, slice_f, slice_com,
                               slice_ci_left, slice_ci_right}), 32'd0);
  endtask

  // Scoreboard monitor: each done pulse must match the oldest queued response.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout", 32'(cout), 32'(e.cout));
        check("zero", 32'(zero), 32'(e.zero));
        check("eq", 32'(eq), 32'(e.eq));
        check("latency", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    func = 3'd0; com = 1'b0; cin = 1'b0; last_res = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    idle_cycle();

    run_op(8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0); idle_cycle();
    run_op(8'hFF, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0); idle_cycle();
    run_op(8'h81, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0); idle_cycle();
    run_op(8'h81, 8'h00, 3'd6, 1'b0, 1'b0, 1'b0); idle_cycle();
    run_op(8'h5A, 8'h5A, 3'd3, 1'b1, 1'b0, 1'b0); idle_cycle();
    // Start during RUN is ignored; start in the DONE cycle is accepted.
    run_op(8'h12, 8'h34, 3'd0, 1'b0, 1'b0, 1'b1);
    run_op(8'h0F, 8'hF0, 3'd2, 1'b0, 1'b0, 1'b0); idle_cycle();

    // Reset at the end of pass 0 aborts the operation without a done pulse.
    op_a = 8'h33; op_b = 8'h44; func = 3'd0; com = 1'b0; cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    last_res = '0;
    repeat (3) idle_cycle();

    for (int i = 0; i < 60; i++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
